// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver.
// A free-running refresh counter (pcnt) divides each frame into one slot per
// digit. The slot index (idx) selects which digit's anode is pulled low. The
// display data loaded by the datapath lands in a shadow copy first. It is only
// committed to the active copy at the frame wrap, so a digit never changes in
// the middle of a frame.
//
// Signal conventions:
//   anode : one-cold and active-low; bit i enables digit i.
//   segs  : active-low, ordered GFEDCBA from bit 6 down to bit 0.
//   dp_n  : active-low decimal point.
// At the start of each slot there is a short ghost window with all anodes off.
// It hides segment-line settling when the display moves from one digit to the
// next.
//
// Handshake: 'load' is a plain one-clock strobe with no back-pressure.
// Whatever sits on digits/blank/dp in that clock is captured, and a later load
// before the next wrap simply overwrites the shadow.

module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GHOST_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     dp,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                segs,
    output logic                      dp_n,
    output logic                      frame_done
);

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int IDX_W  = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEGS_OFF = 7'b1111111;

    // ------------------------------------------------------------------
    // Hex nibble to active-low GFEDCBA pattern
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_segs(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [PCNT_W-1:0] pcnt;
    logic [IDX_W-1:0]  idx;
    logic              tick;
    logic              wrap;

    // End of the current slot, and end of the last slot of the frame.
    assign tick = enable & (pcnt == PCNT_LAST);
    assign wrap = tick & (idx == IDX_LAST);

    // Refresh counter: counts clocks within a slot, forced to 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!enable) begin
            pcnt <= '0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Slot index: advances once per slot. It wraps explicitly after the last
    // digit, so no out-of-range index is reachable for any NUM_DIGITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (!enable) begin
            idx <= '0;
        end else if (tick) begin
            if (wrap) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow / active display data
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_blank;
    logic [NUM_DIGITS-1:0]   active_dp;

    // Shadow capture: a load always wins. pending only clears on a wrap
    // without a fresh load, so a load landing on the wrap clock is kept for
    // the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_blank  <= '0;
            shadow_dp     <= '0;
            pending       <= 1'b0;
        end else if (load) begin
            shadow_digits <= digits;
            shadow_blank  <= blank;
            shadow_dp     <= dp;
            pending       <= 1'b1;
        end else if (wrap) begin
            pending       <= 1'b0;
        end
    end

    // Commit at the frame boundary. This uses the shadow as it was before
    // this clock's load, if there is one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_digits <= '0;
            active_blank  <= '0;
            active_dp     <= '0;
        end else if (wrap && pending) begin
            active_digits <= shadow_digits;
            active_blank  <= shadow_blank;
            active_dp     <= shadow_dp;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and next-output computation
    // ------------------------------------------------------------------
    logic [3:0]            sel_nib;
    logic                  sel_blank;
    logic                  sel_dp;
    logic [NUM_DIGITS-1:0] sel_onecold;
    logic                  in_ghost;
    logic                  dark;

    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            segs_next;
    logic                  dp_n_next;

    // Pick the active data for the digit under scan, and build its one-cold
    // anode mask.
    always_comb begin
        sel_nib     = '0;
        sel_blank   = 1'b0;
        sel_dp      = 1'b0;
        sel_onecold = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nib        = active_digits[4*i +: 4];
                sel_blank      = active_blank[i];
                sel_dp         = active_dp[i];
                sel_onecold[i] = 1'b0;
            end
        end
    end

    // Decide whether this clock is dark (disabled, ghost window or blanked
    // digit). Otherwise light the selected digit.
    always_comb begin
        in_ghost   = (32'(pcnt) < 32'(GHOST_CYCLES));
        dark       = ~enable | in_ghost | sel_blank;
        anode_next = '1;
        segs_next  = SEGS_OFF;
        dp_n_next  = 1'b1;
        if (!dark) begin
            anode_next = sel_onecold;
            segs_next  = hex_to_segs(sel_nib);
            dp_n_next  = ~sel_dp;
        end
    end

    // Register the pin outputs so the board sees glitch-free levels. The
    // async reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode      <= '1;
            segs       <= SEGS_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            anode      <= anode_next;
            segs       <= segs_next;
            dp_n       <= dp_n_next;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with 4 digits, 4 clocks per slot and a 1-clock
// ghost window.
// The reference model tracks the absolute position inside the 16-clock frame,
// and derives slot and phase from it by division. The DUT outputs are compared
// with the model on every clock out of reset. Directed frames pin the model
// with literal segment patterns.

module tb_seven_seg_scanner;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int GH    = 1;
  localparam int FRAME = ND * RD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            enable;
  logic            load;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   blank;
  logic [ND-1:0]   dp;
  logic [ND-1:0]   anode;
  logic [6:0]      segs;
  logic            dp_n;
  logic            frame_done;

  seven_seg_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GHOST_CYCLES(GH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .digits    (digits),
    .blank     (blank),
    .dp        (dp),
    .anode     (anode),
    .segs      (segs),
    .dp_n      (dp_n),
    .frame_done(frame_done)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int            m_pos = 0;
  int            m_slot;
  int            m_phase;
  bit            m_wrap;
  bit            m_pend = 0;
  logic [4*ND-1:0] m_sh_dig = '0, m_act_dig = '0;
  logic [ND-1:0]   m_sh_bl = '0, m_act_bl = '0;
  logic [ND-1:0]   m_sh_dp = '0, m_act_dp = '0;

  logic [ND-1:0] exp_anode = '1;
  logic [6:0]    exp_segs  = 7'h7F;
  logic          exp_dp_n  = 1'b1;
  logic          exp_fd    = 1'b0;
  bit            exp_ghost = 1'b1;

  // The model advances with the DUT clock. It computes what the registered
  // outputs must show after this edge, using the pre-edge frame position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_pend = 0;
      m_sh_dig = '0; m_sh_bl = '0; m_sh_dp = '0;
      m_act_dig = '0; m_act_bl = '0; m_act_dp = '0;
      exp_anode = '1; exp_segs = 7'h7F; exp_dp_n = 1'b1; exp_fd = 1'b0; exp_ghost = 1'b1;
    end else begin
      m_slot    = m_pos / RD;
      m_phase   = m_pos % RD;
      m_wrap    = enable && (m_pos == FRAME - 1);
      exp_ghost = !enable || (m_phase < GH);
      if (exp_ghost || m_act_bl[m_slot]) begin
        exp_anode = '1; exp_segs = 7'h7F; exp_dp_n = 1'b1;
      end else begin
        exp_anode = '1;
        exp_anode[m_slot] = 1'b0;
        exp_segs  = seg_tab[m_act_dig[4*m_slot +: 4]];
        exp_dp_n  = !m_act_dp[m_slot];
      end
      exp_fd = m_wrap;
      if (m_wrap && m_pend) begin
        m_act_dig = m_sh_dig; m_act_bl = m_sh_bl; m_act_dp = m_sh_dp;
      end
      if (load) begin
        m_sh_dig = digits; m_sh_bl = blank; m_sh_dp = dp; m_pend = 1;
      end else if (m_wrap) begin
        m_pend = 0;
      end
      m_pos = enable ? (m_pos + 1) % FRAME : 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("anode", anode, exp_anode);
      chk("segs", segs, exp_segs);
      chk("dp_n", dp_n, exp_dp_n);
      chk("frame_done", frame_done, exp_fd);
      chk("one_cold", ($countones(~anode) <= 1), 1);
      if (exp_ghost) chk("ghost_dark", anode, 4'hF);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    chk("frame_seen", frame_done, 1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    load = 1'b1; digits = d; blank = b; dp = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Literal check of one full frame, starting right after a frame_done
  // negedge. seg_lit packs slot 0 in the low 7 bits.
  task automatic check_frame(input logic [27:0] seg_lit, input logic [3:0] bl, input logic [3:0] dpl);
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    int         slot;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      slot = k / RD;
      if ((k % RD) < GH || bl[slot]) begin
        a = 4'hF; s = 7'h7F; d = 1'b1;
      end else begin
        a = 4'hF; a[slot] = 1'b0;
        s = seg_lit[7*slot +: 7];
        d = ~dpl[slot];
      end
      chk("lit_anode", anode, a);
      chk("lit_segs", segs, s);
      chk("lit_dp_n", dp_n, d);
    end
    chk("lit_frame_end", frame_done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    enable = 1'b0; load = 1'b0; digits = '0; blank = '0; dp = '0;
    repeat (3) @(negedge clk);
    chk("rst_anode", anode, 4'hF);
    chk("rst_segs", segs, 7'h7F);
    chk("rst_dp_n", dp_n, 1);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // T2: 3-2-1-0 with no blanking
    wait_frame();
    do_load(16'h3210, 4'b0000, 4'b0000);
    wait_frame();
    check_frame({7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}, 4'b0000, 4'b0000);

    // T3: F-E-D-A with digit 2 blanked and dp on digit 1
    do_load(16'hFEDA, 4'b0100, 4'b0010);
    wait_frame();
    check_frame({7'b0001110, 7'b0000110, 7'b0100001, 7'b0001000}, 4'b0100, 4'b0010);

    // T4: load in slot 1, then a second load coincident with the wrap
    repeat (5) @(negedge clk);
    do_load(16'h4567, 4'b0000, 4'b0000);
    repeat (9) @(negedge clk);
    do_load(16'h89AB, 4'b0000, 4'b0000);
    chk("t4_wrap_pulse", frame_done, 1);
    check_frame({7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}, 4'b0000, 4'b0000);
    check_frame({7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}, 4'b0000, 4'b0000);

    // T5: disable for 10 clocks in the middle of slot 2
    repeat (9) @(negedge clk);
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t5_anode_off", anode, 4'hF);
      chk("t5_no_frame", frame_done, 0);
    end
    enable = 1'b1;
    check_frame({7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}, 4'b0000, 4'b0000);

    // T1: async reset mid-scan with a pending load that must be discarded
    repeat (6) @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b1111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_anode", anode, 4'hF);
    chk("t1_segs", segs, 7'h7F);
    chk("t1_dp_n", dp_n, 1);
    chk("t1_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    check_frame({4{7'b1000000}}, 4'b0000, 4'b0000);

    // T6: random stimulus checked every clock by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      enable = ($urandom_range(0, 59) != 0);
      load   = ($urandom_range(0, 7) == 0);
      digits = 16'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      dp     = 4'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; load = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
